// File: rtl/alu_pkg.sv
// Shared opcode encodings, datapath width and opcode helpers for the ALU and its sequencer.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;

    // Only the arithmetic opcodes produce a meaningful overflow flag
    function automatic logic is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND/XOR/OR/ADD/SUB with signed add/sub overflow.
// Unrecognised opcodes pass operand1 through unchanged.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] operand1,
    input  logic [DATA_W-1:0] operand2,
    input  logic [2:0]        aluop,
    output logic [DATA_W-1:0] alu_out,
    output logic              add_sub_overflow
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;

    assign w_sum  = operand1 + operand2;
    assign w_diff = operand1 - operand2;

    // Signed overflow: result sign disagrees with what the operand signs allow
    assign w_add_ovf = (operand1[DATA_W-1] == operand2[DATA_W-1]) && (w_sum[DATA_W-1]  != operand1[DATA_W-1]);
    assign w_sub_ovf = (operand1[DATA_W-1] != operand2[DATA_W-1]) && (w_diff[DATA_W-1] != operand1[DATA_W-1]);

    assign add_sub_overflow = (aluop == OP_SUB) ? w_sub_ovf : w_add_ovf;

    // Result mux selected by opcode
    always_comb begin
        alu_out = operand1;
        case (aluop)
            OP_AND:  alu_out = operand1 & operand2;
            OP_XOR:  alu_out = operand1 ^ operand2;
            OP_OR:   alu_out = operand1 | operand2;
            OP_ADD:  alu_out = w_sum;
            OP_SUB:  alu_out = w_diff;
            default: alu_out = operand1;
        endcase
    end

endmodule

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an event leaves the count at one.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    // Clear takes priority, then the current event is counted; sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (clr) begin
            r_cnt <= inc ? CNT_ONE : {CNT_W{1'b0}};
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Two-stage valid/ready front-end for the combinational ALU: S1 holds the issued command
// and drives the ALU, S2 holds the tagged result; overflow and command statistics on retirement.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic [TAG_W-1:0]  rsp_tag,
    input  logic              stat_clr,
    output logic              stat_ovf_sticky,
    output logic [CNT_W-1:0]  stat_cmd_cnt,
    output logic [CNT_W-1:0]  stat_ovf_cnt
);

    logic              r_s1_valid;
    logic [2:0]        r_s1_op;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [TAG_W-1:0]  r_s1_tag;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_ovf;
    logic [TAG_W-1:0]  r_s2_tag;

    logic              r_ovf_sticky;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_cmd_fire;
    logic              w_rsp_fire;
    logic              w_ovf_fire;
    logic [DATA_W-1:0] w_alu_out;
    logic              w_alu_ovf;

    assign w_s2_adv   = !r_s2_valid || rsp_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign cmd_ready  = w_s1_adv && !rst;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_rsp_fire = r_s2_valid && rsp_ready;
    assign w_ovf_fire = w_rsp_fire && r_s2_ovf;

    // S1: capture the command on handshake, otherwise hold or drain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 3'b000;
            r_s1_a     <= {DATA_W{1'b0}};
            r_s1_b     <= {DATA_W{1'b0}};
            r_s1_tag   <= {TAG_W{1'b0}};
        end else begin
            r_s1_valid <= w_s1_adv ? w_cmd_fire : r_s1_valid;
            if (w_cmd_fire) begin
                r_s1_op  <= cmd_op;
                r_s1_a   <= cmd_a;
                r_s1_b   <= cmd_b;
                r_s1_tag <= cmd_tag;
            end else begin
                r_s1_op  <= r_s1_op;
                r_s1_a   <= r_s1_a;
                r_s1_b   <= r_s1_b;
                r_s1_tag <= r_s1_tag;
            end
        end
    end

    alu u_alu (
        .operand1         (r_s1_a),
        .operand2         (r_s1_b),
        .aluop            (r_s1_op),
        .alu_out          (w_alu_out),
        .add_sub_overflow (w_alu_ovf)
    );

    // S2: latch the ALU result when it can advance; payload is held under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= {DATA_W{1'b0}};
            r_s2_ovf   <= 1'b0;
            r_s2_tag   <= {TAG_W{1'b0}};
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_alu_out;
                r_s2_ovf  <= is_addsub(r_s1_op) && w_alu_ovf;
                r_s2_tag  <= r_s1_tag;
            end else begin
                r_s2_data <= r_s2_data;
                r_s2_ovf  <= r_s2_ovf;
                r_s2_tag  <= r_s2_tag;
            end
        end else begin
            r_s2_valid <= r_s2_valid;
            r_s2_data  <= r_s2_data;
            r_s2_ovf   <= r_s2_ovf;
            r_s2_tag   <= r_s2_tag;
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_data  = r_s2_data;
    assign rsp_ovf   = r_s2_ovf;
    assign rsp_tag   = r_s2_tag;

    // Sticky overflow: a clear coinciding with a retirement leaves that retirement's flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (stat_clr) begin
            r_ovf_sticky <= w_ovf_fire;
        end else begin
            r_ovf_sticky <= r_ovf_sticky || w_ovf_fire;
        end
    end

    assign stat_ovf_sticky = r_ovf_sticky;

    sat_counter #(.CNT_W(CNT_W)) u_cmd_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_rsp_fire),
        .clr (stat_clr),
        .cnt (stat_cmd_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_ovf_fire),
        .clr (stat_clr),
        .cnt (stat_ovf_cnt)
    );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table streamed at full rate, plus hand-written
// latency, backpressure, statistics-clear and mid-flight reset sequences.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_ovf;
    logic [3:0]  rsp_tag;
    logic        stat_clr;
    logic        stat_ovf_sticky;
    logic [15:0] stat_cmd_cnt;
    logic [15:0] stat_ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cur_exp_data;
    logic        cur_exp_ovf;
    exp_t        exp_q[$];

    vec_t tbl[10];
    vec_t bp[3];
    vec_t first_add;

    alu_cmd_sequencer #(.TAG_W(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .cmd_tag         (cmd_tag),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_ovf         (rsp_ovf),
        .rsp_tag         (rsp_tag),
        .stat_clr        (stat_clr),
        .stat_ovf_sticky (stat_ovf_sticky),
        .stat_cmd_cnt    (stat_cmd_cnt),
        .stat_ovf_cnt    (stat_ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cmd_op       = v.op;
        cmd_a        = v.a;
        cmd_b        = v.b;
        cmd_tag      = v.tag;
        cur_exp_data = v.exp_data;
        cur_exp_ovf  = v.exp_ovf;
        cmd_valid    = 1'b1;
    endtask

    // Scoreboard: expectations queued at accept, compared in order at retirement
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stale_rsp: got tag %0d data 0x%08h, want no response", rsp_tag, rsp_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("rsp_data tag%0d", e.tag), rsp_data, e.data);
                    chk($sformatf("rsp_ovf tag%0d", e.tag), 32'(rsp_ovf), 32'(e.ovf));
                    chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{data: cur_exp_data, ovf: cur_exp_ovf, tag: cmd_tag});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic acc;

        first_add = '{OP_ADD, 32'd32, 32'd34, 4'd3, 32'h0000_0042, 1'b0};
        tbl[0] = '{OP_SUB, 32'd32,         32'd34,         4'd1,  32'hFFFF_FFFE, 1'b0};
        tbl[1] = '{OP_AND, 32'd32,         32'd34,         4'd2,  32'h0000_0020, 1'b0};
        tbl[2] = '{OP_XOR, 32'd32,         32'd34,         4'd3,  32'h0000_0002, 1'b0};
        tbl[3] = '{OP_ADD, 32'h7FFF_FFFF,  32'h0000_0001,  4'd4,  32'h8000_0000, 1'b1};
        tbl[4] = '{OP_SUB, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  4'd5,  32'h8000_0000, 1'b1};
        tbl[5] = '{OP_OR,  32'h7FFF_FFFF,  32'h0000_0001,  4'd6,  32'h7FFF_FFFF, 1'b0};
        tbl[6] = '{OP_ADD, 32'h8000_0000,  32'h8000_0000,  4'd7,  32'h0000_0000, 1'b1};
        tbl[7] = '{OP_SUB, 32'h8000_0000,  32'h0000_0001,  4'd8,  32'h7FFF_FFFF, 1'b1};
        tbl[8] = '{OP_ADD, 32'hFFFF_FFFF,  32'h0000_0001,  4'd9,  32'h0000_0000, 1'b0};
        tbl[9] = '{OP_SUB, 32'h0000_0000,  32'h8000_0000,  4'd15, 32'h8000_0000, 1'b1};
        bp[0]  = '{OP_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  4'd10, 32'h00F0_00F0, 1'b0};
        bp[1]  = '{OP_OR,  32'h1234_0000,  32'h0000_5678,  4'd11, 32'h1234_5678, 1'b0};
        bp[2]  = '{OP_XOR, 32'hFFFF_FFFF,  32'h0000_FFFF,  4'd12, 32'hFFFF_0000, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_tag = 4'd0; rsp_ready = 1'b1; stat_clr = 1'b0;
        cur_exp_data = 32'd0; cur_exp_ovf = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", rsp_data, 32'd0);
        chk("rst stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);

        // Single ADD: response two cycles after the accepting cycle
        @(posedge clk); #1 drive(first_add);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk); chk("lat +1 rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk); chk("lat +2 rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        @(negedge clk); chk("single stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd1);

        // Table vectors streamed one per cycle
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            @(negedge clk); chk($sformatf("tbl%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("tbl stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd11);
        chk("tbl stat_ovf_cnt", 32'(stat_ovf_cnt), 32'd5);
        chk("tbl sticky", 32'(stat_ovf_sticky), 32'd1);
        chk("tbl drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: rsp_ready low for 5 cycles while 3 commands are offered
        @(posedge clk); #1;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 3; cyc++) begin
            rsp_ready = (cyc >= 5);
            drive(bp[idx]);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
                chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
                chk("bp hold rsp_data", rsp_data, bp[0].exp_data);
                chk("bp hold rsp_tag", 32'(rsp_tag), 32'(bp[0].tag));
            end
            acc = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (cyc == 4) chk("bp accepted", 32'(idx), 32'd2);
        end
        chk("bp all accepted", 32'(idx), 32'd3);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp drained", 32'(exp_q.size()), 32'd0);
        chk("bp stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd14);

        // stat_clr coinciding with an overflowing retirement, then stat_clr alone
        @(posedge clk); #1 drive(tbl[3]);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); #1 stat_clr = 1'b1;
        @(negedge clk); chk("clr+ret rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("clr+ret stat_ovf_cnt", 32'(stat_ovf_cnt), 32'd1);
        chk("clr+ret stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd1);
        chk("clr+ret sticky", 32'(stat_ovf_sticky), 32'd1);
        @(posedge clk); #1 stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        chk("clr stat_ovf_cnt", 32'(stat_ovf_cnt), 32'd0);
        chk("clr stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd0);
        chk("clr sticky", 32'(stat_ovf_sticky), 32'd0);

        // Reset with two commands in flight: nothing may come out afterwards
        @(posedge clk); #1 rsp_ready = 1'b0; drive(tbl[3]);
        @(posedge clk); #1 drive(tbl[4]);
        @(posedge clk); #1 cmd_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst rsp_data", rsp_data, 32'd0);
        chk("midrst rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("midrst rsp_tag", 32'(rsp_tag), 32'd0);
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("midrst stat_cmd_cnt", 32'(stat_cmd_cnt), 32'd0);
        chk("midrst rsp_valid late", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
